// File: rtl/cnn_acc_pkg.sv
// ---------------------------------------------------------------------------
// cnn_acc_pkg
// Shared widths, output clamp limits and the accumulator FSM state encoding
// for the CNN multiply-accumulate saturation block.
// ---------------------------------------------------------------------------
package cnn_acc_pkg;

    // Output format is ap_fixed<14,6>; products arrive as Q(21,14 frac).
    localparam int OUT_WIDTH  = 32'sd14;
    localparam int PROD_WIDTH = 32'sd21;
    localparam int OUT_MAX    = 32'sd8191;
    localparam int OUT_MIN    = -32'sd8192;

    // ACC   : taking products (prod_ready high)
    // FINAL : one cycle to shift/saturate/ReLU and register the result
    // OUT   : presenting the result until the consumer takes it
    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FINAL = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_acc_sat_core.sv
// ---------------------------------------------------------------------------
// cnn_acc_sat_core
// Combinational post-processing of a finished accumulator value:
// arithmetic right shift into output format, clamp to the 14-bit signed
// range, then optional ReLU.
//   acc_in   : accumulator value, ACC_WIDTH bits, signed, product format
//   relu_en  : force negative results to zero
//   data_out : result in ap_fixed<14,6>
//   sat_out  : high when the range clamp altered the value (ReLU never sets it)
// ---------------------------------------------------------------------------
module cnn_acc_sat_core
    import cnn_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = 32'sd29,
    parameter int FRAC_SHIFT = 32'sd6
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic                        relu_en,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_out
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_C = ACC_WIDTH'(OUT_MAX);
    localparam logic signed [ACC_WIDTH-1:0] MIN_C = ACC_WIDTH'(OUT_MIN);

    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic signed [OUT_WIDTH-1:0] clamp_s;

    // Shift (floor toward minus infinity), clamp, then ReLU on the clamped value.
    always_comb begin
        shifted_s = acc_in >>> FRAC_SHIFT;
        clamp_s   = shifted_s[OUT_WIDTH-1:0];
        sat_out   = 1'b0;
        if (shifted_s > MAX_C) begin
            clamp_s = OUT_WIDTH'(OUT_MAX);
            sat_out = 1'b1;
        end else if (shifted_s < MIN_C) begin
            clamp_s = OUT_WIDTH'(OUT_MIN);
            sat_out = 1'b1;
        end else begin
            clamp_s = shifted_s[OUT_WIDTH-1:0];
        end

        if (relu_en && clamp_s[OUT_WIDTH-1]) begin
            data_out = {OUT_WIDTH{1'b0}};
        end else begin
            data_out = clamp_s;
        end
    end

endmodule

// File: rtl/cnn_acc_sat.sv
// ---------------------------------------------------------------------------
// cnn_acc_sat
// Accumulates N_TERMS signed products (plus a bias loaded on the first term
// of each group), then converts the sum to ap_fixed<14,6> with saturation and
// optional ReLU. Product intake stops while a result is being finished or
// waiting for the consumer, so groups never overlap.
//   ap_clk / ap_rst       : clock, asynchronous active-high reset
//   prod_din/valid/ready  : product stream (ready only while accumulating)
//   bias_din              : bias in ap_fixed<14,6>, used on the first term
//   relu_en               : sampled in the finishing cycle only
//   out_data/valid/ready  : result handshake, result held until taken
//   sat_flag              : result was clamped to the 14-bit range
// ---------------------------------------------------------------------------
module cnn_acc_sat
    import cnn_acc_pkg::*;
#(
    parameter int N_TERMS    = 32'sd25,
    parameter int ACC_WIDTH  = 32'sd29,
    parameter int FRAC_SHIFT = 32'sd6
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic signed [PROD_WIDTH-1:0] prod_din,
    input  logic                         prod_valid,
    output logic                         prod_ready,
    input  logic signed [OUT_WIDTH-1:0]  bias_din,
    input  logic                         relu_en,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         sat_flag
);

    // Wide enough to hold N_TERMS-1 for every legal N_TERMS (1..256).
    localparam int CNT_W = $clog2(N_TERMS + 32'sd1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_TERMS - 32'sd1);

    state_t                        state_r, state_next_s;
    logic [CNT_W-1:0]              count_r, count_next_s;
    logic signed [ACC_WIDTH-1:0]   acc_r, acc_next_s;
    logic signed [OUT_WIDTH-1:0]   out_data_r, out_data_next_s;
    logic                          sat_flag_r, sat_next_s;
    logic                          out_valid_r, out_valid_next_s;
    logic                          prod_ready_r, prod_ready_next_s;

    logic                          xfer_s;
    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [ACC_WIDTH-1:0]   bias_sh_s;
    logic signed [OUT_WIDTH-1:0]   core_data_s;
    logic                          core_sat_s;

    cnn_acc_sat_core #(
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_core (
        .acc_in   (acc_r),
        .relu_en  (relu_en),
        .data_out (core_data_s),
        .sat_out  (core_sat_s)
    );

    // Sign-extended operands; the bias is moved from output format into
    // product format by the same shift the core undoes.
    always_comb begin
        prod_ext_s = ACC_WIDTH'(prod_din);
        bias_sh_s  = ACC_WIDTH'(bias_din) <<< FRAC_SHIFT;
        xfer_s     = prod_valid && prod_ready_r && (state_r == ACC);
    end

    // Next-state and datapath next values; everything holds by default.
    always_comb begin
        state_next_s     = state_r;
        count_next_s     = count_r;
        acc_next_s       = acc_r;
        out_data_next_s  = out_data_r;
        sat_next_s       = sat_flag_r;
        out_valid_next_s = out_valid_r;
        case (state_r)
            ACC: begin
                if (xfer_s) begin
                    if (count_r == {CNT_W{1'b0}}) begin
                        acc_next_s = prod_ext_s + bias_sh_s;
                    end else begin
                        acc_next_s = acc_r + prod_ext_s;
                    end
                    if (count_r == LAST_C) begin
                        count_next_s = {CNT_W{1'b0}};
                        state_next_s = FINAL;
                    end else begin
                        count_next_s = count_r + CNT_W'(1'b1);
                    end
                end else begin
                    state_next_s = ACC;
                end
            end
            FINAL: begin
                out_data_next_s = core_data_s;
                sat_next_s      = core_sat_s;
                state_next_s    = OUT;
            end
            OUT: begin
                // First OUT cycle raises valid; afterwards wait for the consumer.
                if (out_valid_r) begin
                    if (out_ready) begin
                        out_valid_next_s = 1'b0;
                        state_next_s     = ACC;
                    end else begin
                        out_valid_next_s = 1'b1;
                    end
                end else begin
                    out_valid_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s     = ACC;
                count_next_s     = {CNT_W{1'b0}};
                acc_next_s       = {ACC_WIDTH{1'b0}};
                out_valid_next_s = 1'b0;
            end
        endcase
        prod_ready_next_s = (state_next_s == ACC);
    end

    // State and datapath registers; ready stays low through reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_r      <= ACC;
            count_r      <= {CNT_W{1'b0}};
            acc_r        <= {ACC_WIDTH{1'b0}};
            out_data_r   <= {OUT_WIDTH{1'b0}};
            sat_flag_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            prod_ready_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            acc_r        <= acc_next_s;
            out_data_r   <= out_data_next_s;
            sat_flag_r   <= sat_next_s;
            out_valid_r  <= out_valid_next_s;
            prod_ready_r <= prod_ready_next_s;
        end
    end

    assign out_data   = out_data_r;
    assign sat_flag   = sat_flag_r;
    assign out_valid  = out_valid_r;
    assign prod_ready = prod_ready_r;

endmodule

// File: tb/tb_cnn_acc_sat.sv
module tb_cnn_acc_sat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0 drives the N_TERMS=4 instance, index 1 the N_TERMS=1 instance.
    logic [1:0]         pv   = 2'b00;
    logic [1:0]         relu = 2'b00;
    logic [1:0]         ordy = 2'b00;
    logic signed [20:0] pd0 = 21'sd0, pd1 = 21'sd0;
    logic signed [13:0] bd0 = 14'sd0, bd1 = 14'sd0;

    logic               pr4, ov4, sf4, pr1, ov1, sf1;
    logic signed [13:0] od4, od1;

    cnn_acc_sat #(.N_TERMS(4)) dut4 (
        .ap_clk(clk), .ap_rst(rst), .prod_din(pd0), .prod_valid(pv[0]),
        .prod_ready(pr4), .bias_din(bd0), .relu_en(relu[0]), .out_data(od4),
        .out_valid(ov4), .out_ready(ordy[0]), .sat_flag(sf4));

    cnn_acc_sat #(.N_TERMS(1)) dut1 (
        .ap_clk(clk), .ap_rst(rst), .prod_din(pd1), .prod_valid(pv[1]),
        .prod_ready(pr1), .bias_din(bd1), .relu_en(relu[1]), .out_data(od1),
        .out_valid(ov1), .out_ready(ordy[1]), .sat_flag(sf1));

    typedef struct { int data; bit sat; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic g_pr(int d); return (d == 0) ? pr4 : pr1; endfunction
    function automatic logic g_ov(int d); return (d == 0) ? ov4 : ov1; endfunction
    function automatic logic g_sf(int d); return (d == 0) ? sf4 : sf1; endfunction
    function automatic logic signed [13:0] g_od(int d); return (d == 0) ? od4 : od1; endfunction

    task automatic set_prod(int d, logic signed [20:0] v);
        if (d == 0) pd0 = v; else pd1 = v;
    endtask

    // Reference: bias*64 + sum, floor-divide by 64, clamp, ReLU.
    task automatic model(input int n, input int p[4], input int bias, input bit r,
                         output exp_t e);
        longint sum, q;
        sum = longint'(bias) * 64;
        for (int i = 0; i < n; i++) sum += p[i];
        q = sum / 64;
        if (sum < 0 && (sum % 64) != 0) q = q - 1;
        e.sat = 1'b0;
        if (q > 8191) begin q = 8191; e.sat = 1'b1; end
        else if (q < -8192) begin q = -8192; e.sat = 1'b1; end
        if (r && q < 0) q = 0;
        e.data = int'(q);
    endtask

    task automatic run_group(input int d, input int n, input int p0, input int p1,
                             input int p2, input int p3, input int bias,
                             input bit r, input int hold, input string tag);
        int   p[4];
        int   lat, g;
        exp_t e, got;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        model(n, p, bias, r, e);
        sb.push_back(e);
        @(negedge clk);
        if (d == 0) bd0 = 14'(bias); else bd1 = 14'(bias);
        relu[d] = r;
        g = 0;
        while (!g_pr(d) && g < 20) begin @(negedge clk); g++; end
        check({tag, "_ready_wait"}, g_pr(d), 1);
        for (int i = 0; i < n; i++) begin
            pv[d] = 1'b1;
            set_prod(d, 21'(p[i]));
            @(posedge clk);
            @(negedge clk);
        end
        pv[d] = 1'b0;
        lat = 1;
        while (!g_ov(d) && lat < 20) begin @(negedge clk); lat++; end
        check({tag, "_latency"}, lat, 3);
        got = sb.pop_front();
        check({tag, "_data"}, g_od(d), got.data);
        check({tag, "_sat"}, g_sf(d), got.sat);
        for (int k = 0; k < hold; k++) begin
            check({tag, "_hold_valid"}, g_ov(d), 1);
            check({tag, "_hold_data"}, g_od(d), got.data);
            check({tag, "_hold_ready"}, g_pr(d), 0);
            pv[d] = 1'b1;
            set_prod(d, 21'sd300000);
            @(negedge clk);
        end
        pv[d] = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[d] = 1'b0;
        check({tag, "_accept_valid"}, g_ov(d), 0);
        check({tag, "_accept_ready"}, g_pr(d), 1);
    endtask

    initial begin
        int seen;
        // Reset state.
        @(negedge clk);
        check("rst_data", od4, 0);
        check("rst_valid", ov4, 0);
        check("rst_sat", sf4, 0);
        check("rst_ready", pr4, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", pr4, 1);

        // N_TERMS=4 groups.
        run_group(0, 4, 16384, 16384, 16384, 16384, 0, 1'b0, 0, "unity");
        run_group(0, 4, 1048575, 1048575, 1048575, 1048575, 0, 1'b0, 0, "sat_pos");
        run_group(0, 4, -1048576, -1048576, -1048576, -1048576, 0, 1'b0, 0, "sat_neg");
        run_group(0, 4, -1048576, -1048576, -1048576, -1048576, 0, 1'b1, 0, "sat_relu");
        run_group(0, 4, 1000, -3000, 200000, -7, -100, 1'b0, 3, "hold");
        run_group(0, 4, -5000, 64, 129, 0, 10, 1'b0, 0, "after_hold");
        run_group(0, 4, -6400, 0, 0, 0, 0, 1'b1, 0, "relu_nosat");

        // N_TERMS=1 boundaries.
        run_group(1, 1, -1, 0, 0, 0, 0, 1'b0, 0, "floor_m1");
        run_group(1, 1, 63, 0, 0, 0, 0, 1'b0, 0, "floor_63");
        run_group(1, 1, 0, 0, 0, 0, 256, 1'b0, 0, "bias256");
        run_group(1, 1, -65, 0, 0, 0, 0, 1'b0, 0, "floor_m65");

        // Reset after 2 of 4 transfers discards the partial group.
        @(negedge clk);
        bd0 = 14'sd0;
        relu[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pv[0] = 1'b1;
            pd0 = 21'sd1048575;
            @(posedge clk);
            @(negedge clk);
        end
        pv[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", ov4, 0);
        check("midrst_ready", pr4, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov4) seen++;
        end
        check("midrst_no_output", seen, 0);
        run_group(0, 4, 16384, 32768, -16384, 64, 2, 1'b0, 0, "post_rst");

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
